// File: rtl/score_bus_pkg.sv
// Shared packet layout, FSM encoding and field helpers for the score broadcast bus.
package score_bus_pkg;

  localparam int VALID_BIT = 0;
  localparam int NODE_LSB  = 1;
  localparam int NODE_W    = 6;
  localparam int SCORE_LSB = 7;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  function automatic logic [NODE_W-1:0] get_node(input logic [SCORE_LSB-1:NODE_LSB] pkt_node);
    return pkt_node[NODE_LSB +: NODE_W];
  endfunction

endpackage

// File: rtl/score_fifo.sv
// Single-clock FIFO; dout shows the head combinationally, write visible one edge after push.
// Caller must not push when full (unless popping) nor pop when empty.
module score_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/score_bus_arbiter.sv
// Round-robin share of one score broadcast bus among NUM_CPU cores, with iteration tracking and halt.
// One-cycle registered bus after FIFO head; a full FIFO drops the push and flags overflow.
module score_bus_arbiter
  import score_bus_pkg::*;
#(
  parameter int NUM_CPU = 4,
  parameter int WIDTH   = 31,
  parameter int NODES   = 64,
  parameter int DEPTH   = 16,
  parameter int ITER_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CPU-1:0]       wr_valid,
  input  logic [NUM_CPU*WIDTH-1:0] wr_data,
  input  logic [ITER_W-1:0]        max_iter,
  input  logic                     restart,
  output logic [WIDTH-1:0]         bus_data,
  output logic                     bus_valid,
  output logic                     iter_done,
  output logic [ITER_W-1:0]        iter_count,
  output logic                     halt,
  output logic [NUM_CPU-1:0]       overflow,
  output logic                     dup_err
);

  localparam int PTR_W = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;
  localparam int CNT_W = $clog2(NODES);
  localparam logic [PTR_W-1:0]  PTR_ONE  = 1;
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(NUM_CPU - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NODES - 1);
  localparam logic [ITER_W-1:0] ITER_ONE = 1;

  state_t state, state_nxt;

  logic [NUM_CPU-1:0] wr_en, push, pop, empty, full;
  logic [WIDTH-1:0]   head [NUM_CPU];
  logic [WIDTH-1:0]   head_sel;
  logic [PTR_W-1:0]   rr_ptr, rr_nxt, gnt_idx;
  logic               gnt_vld;
  int                 cand;
  logic [CNT_W-1:0]   pkt_cnt;
  logic [NODES-1:0]   seen;
  logic [NODE_W-1:0]  gnt_node;
  logic               last_pkt;
  logic [ITER_W-1:0]  iter_inc;

  for (genvar i = 0; i < NUM_CPU; i++) begin : g_cpu
    assign wr_en[i] = wr_valid[i] & wr_data[i*WIDTH + VALID_BIT];
    assign pop[i]   = gnt_vld & (gnt_idx == PTR_W'(i));
    // A full FIFO still takes the push when its head leaves in the same cycle.
    assign push[i]  = wr_en[i] & (~full[i] | pop[i]);

    score_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (wr_data[i*WIDTH +: WIDTH]),
      .dout  (head[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

  // Scan downwards so the lowest offset from rr_ptr is written last and wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    if (state == RUN) begin
      for (int k = NUM_CPU - 1; k >= 0; k--) begin
        cand = (int'(rr_ptr) + k) % NUM_CPU;
        if (!empty[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = PTR_W'(cand);
        end
      end
    end
  end

  assign head_sel = head[gnt_idx];
  assign gnt_node = get_node(head_sel[SCORE_LSB-1:NODE_LSB]);
  assign rr_nxt   = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + PTR_ONE;
  assign last_pkt = gnt_vld && (pkt_cnt == CNT_LAST);
  assign iter_inc = iter_count + ITER_ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_data   <= '0;
      bus_valid  <= 1'b0;
      iter_done  <= 1'b0;
      iter_count <= '0;
      overflow   <= '0;
      dup_err    <= 1'b0;
      rr_ptr     <= '0;
      pkt_cnt    <= '0;
      seen       <= '0;
    end else begin
      bus_valid <= gnt_vld;
      bus_data  <= gnt_vld ? head_sel : '0;
      iter_done <= last_pkt;
      overflow  <= overflow | (wr_en & full & ~pop);
      if (gnt_vld) rr_ptr <= rr_nxt;
      if (gnt_vld && seen[gnt_node]) dup_err <= 1'b1;
      if (restart) begin
        pkt_cnt    <= '0;
        seen       <= '0;
        iter_count <= '0;
      end else if (last_pkt) begin
        pkt_cnt    <= '0;
        seen       <= '0;
        iter_count <= iter_inc;
      end else if (gnt_vld) begin
        pkt_cnt        <= pkt_cnt + CNT_ONE;
        seen[gnt_node] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (last_pkt && (max_iter != '0) && (iter_inc == max_iter)) state_nxt = HALT;
      HALT:    if (restart) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    if (restart) state_nxt = RUN;
  end

  assign halt = (state == HALT);

endmodule

// File: doc/score_bus_arbiter.md
Name: score_bus_arbiter

Overview:
- Shares one score broadcast bus between NUM_CPU partition cores.
- Each partition core emits score packets {score[WIDTH-1:7], node_id[6:1], valid[0]} on its own write strobe. This block buffers each core's packets in a per-core FIFO, picks one core per cycle round-robin, and drives the common dataIn bus that feeds every core.
- Counts broadcasts per PageRank iteration, reports iteration completion and duplicate node IDs, and halts the bus after a programmable number of iterations.

Parameters:
- NUM_CPU, 4, number of partition cores (requesters).
- WIDTH, 31, packet width; layout {score[WIDTH-8:0], node_id[5:0], valid}.
- NODES, 64, graph nodes per iteration; must equal 2^6.
- DEPTH, 16, entries per requester FIFO; must be a power of 2, >= 2.
- ITER_W, 8, width of the iteration counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- wr_valid  in  NUM_CPU  per-core write strobe (core writeL).
- wr_data  in  NUM_CPU*WIDTH  per-core packet; core i occupies bits [i*WIDTH +: WIDTH].
- max_iter  in  ITER_W  number of iterations before halt; 0 = never halt.
- restart  in  1  single-cycle pulse; clears counters and leaves HALT.
- bus_data  out  WIDTH  broadcast packet to all cores' dataIn.
- bus_valid  out  1  bus_data carries a granted packet.
- iter_done  out  1  one-cycle pulse when NODES packets have been broadcast.
- iter_count  out  ITER_W  number of completed iterations.
- halt  out  1  high in the HALT state.
- overflow  out  NUM_CPU  sticky flag per core: a packet was dropped because the FIFO was full.
- dup_err  out  1  sticky flag: the same node_id was broadcast twice within one iteration.

Behaviour:
- Reset (asynchronous, reset=0): all outputs 0, FIFOs empty, RR pointer 0, packet count 0, seen bitmap 0, state RUN.
- Push: core i writes when wr_valid[i]=1 and wr_data[i][0]=1. A strobe with bit0=0 is ignored.
- Full FIFO: the push is dropped and overflow[i] is set. Exception: if the same FIFO pops in that cycle, the push is accepted.
- Pops happen only for the granted core, so push and pop may both occur in one cycle.
- Arbitration:
  - Combinational, evaluated in RUN only.
  - Grant goes to the first non-empty FIFO at or after the RR pointer, wrapping modulo NUM_CPU.
  - On a grant, the pointer becomes (grant+1) mod NUM_CPU. With no grant the pointer holds.
- Bus is registered:
  - On a grant: bus_data <= FIFO head, bus_valid <= 1.
  - Otherwise: bus_data <= 0, bus_valid <= 0. A zero packet is invalid to the cores.
- Latency: a packet pushed at edge t into an empty FIFO, with no contention, appears on the bus after edge t+1.
- Throughput: 1 packet/cycle aggregate. With all FIFOs busy, each core gets 1 slot per NUM_CPU cycles.
- Iteration tracking (on each grant):
  - pkt_cnt increments. Bit node_id is set in the seen bitmap; if that bit was already set, dup_err <= 1.
  - When pkt_cnt = NODES-1 and a grant occurs:
    - pkt_cnt <= 0, seen <= 0.
    - iter_done pulses high in the same cycle the last packet appears on bus_valid.
    - iter_count <= iter_count+1, wrapping at 2^ITER_W.
- States:
  - RUN -> HALT when an iteration completes and max_iter != 0 and the new iter_count = max_iter.
  - HALT -> RUN on restart=1.
  - In HALT there are no grants: bus_valid=0, halt=1. FIFOs still accept pushes and overflow as normal.
- restart (any state):
  - Clears pkt_cnt, seen and iter_count; state becomes RUN.
  - Does not clear FIFOs, overflow or dup_err; only reset clears the sticky flags.
  - If restart coincides with iteration completion, restart wins: iter_count=0, no HALT transition. iter_done still pulses.
- Reset mid-operation: FIFO contents are lost immediately and the bus drops to 0 asynchronously.

Decomposition:
- Package score_bus_pkg:
  - Packet field offsets: VALID_BIT=0, NODE_LSB=1, NODE_W=6, SCORE_LSB=7.
  - State encoding: RUN, HALT.
  - Helper function extracting node_id from a packet.
- Sub-module score_fifo:
  - Synchronous single-clock FIFO with DEPTH entries, WIDTH bits.
  - Ports: push, pop, din, dout, empty, full.
  - Uses the same clk/reset; instantiated NUM_CPU times.
- Arbiter, counters and FSM stay in the top level.

Test Plan:
- Single core: core 0 pushes node_id 0..15 with score 24'h040000 on consecutive cycles -> bus shows packets in order, first at push+1 cycle, bus_valid continuous for 16 cycles, no iter_done.
- Round-robin: all 4 cores push 16 packets in the same 16 cycles (node_ids 16*i+k) -> bus order core0,1,2,3,0,...; 64 broadcasts; iter_done pulses with the 64th; iter_count=1; dup_err=0; overflow=0.
- Halt: max_iter=2, two full 64-packet iterations -> iter_count=2, halt=1. A further push is stored but not broadcast. A restart pulse -> halt=0, stored packet broadcast next cycle, iter_count=0.
- Overflow: block granting via HALT; core 2 pushes 17 packets -> overflow=4'b0100, FIFO holds the first 16. After restart exactly 16 packets are broadcast.
- Duplicate: core 1 sends node_id 5 twice within one iteration -> dup_err=1 after the second broadcast and stays 1 after the iteration ends.
- Reset mid-burst: assert reset=0 with 8 packets queued -> bus_data=0 and bus_valid=0 immediately; after release no packets emerge; all counters read 0.
